sprite_dispatcher: RTL and testbench

//  Pulls sprite draw commands from the sprite draw queue and dispatches each one to a free

---
 rtl/sprite_dispatcher_if.sv | 47 ++++
 rtl/sprite_dispatcher.sv | 140 ++++++++++++++
 tb/tb_sprite_dispatcher.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_dispatcher_if.sv
// Sprite dispatcher bus: queue head, per-engine commands,
// and the shared sprite-memory read port.
interface sprite_dispatcher_if #(
  parameter int NUM_R  = 2,
  parameter int ADDR_W = 13
);
  logic                    sprite_queue_is_empty;
  logic [7:0]              sprite_queue_sprite_id;
  logic [15:0]             sprite_queue_sprite_x;
  logic [15:0]             sprite_queue_sprite_y;
  logic [7:0]              sprite_queue_sprite_scale;
  logic                    sprite_queue_dequeue;
  logic [NUM_R-1:0]        r_start;
  logic [NUM_R*8-1:0]      r_id;
  logic [NUM_R*16-1:0]     r_x;
  logic [NUM_R*16-1:0]     r_y;
  logic [NUM_R*8-1:0]      r_scale;
  logic [NUM_R-1:0]        r_done;
  logic [NUM_R-1:0]        r_mem_req;
  logic [NUM_R*ADDR_W-1:0] r_mem_addr;
  logic [NUM_R-1:0]        r_mem_grant;
  logic [NUM_R-1:0]        r_mem_valid;
  logic                    sprite_r_en;
  logic [ADDR_W-1:0]       sprite_r_addr;

  modport master (
    input  sprite_queue_is_empty, sprite_queue_sprite_id,
    input  sprite_queue_sprite_x, sprite_queue_sprite_y,
    input  sprite_queue_sprite_scale,
    input  r_done, r_mem_req, r_mem_addr,
    output sprite_queue_dequeue, r_start,
    output r_id, r_x, r_y, r_scale,
    output r_mem_grant, r_mem_valid,
    output sprite_r_en, sprite_r_addr
  );

  modport slave (
    output sprite_queue_is_empty, sprite_queue_sprite_id,
    output sprite_queue_sprite_x, sprite_queue_sprite_y,
    output sprite_queue_sprite_scale,
    output r_done, r_mem_req, r_mem_addr,
    input  sprite_queue_dequeue, r_start,
    input  r_id, r_x, r_y, r_scale,
    input  r_mem_grant, r_mem_valid,
    input  sprite_r_en, sprite_r_addr
  );
endinterface

// File: rtl/sprite_dispatcher.sv
// Dispatches queued sprite commands to free render engines
// and round-robin arbitrates the shared sprite-memory port.
module sprite_dispatcher #(
  parameter int NUM_R  = 2,
  parameter int ADDR_W = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic fb_resetting,
  output logic frame_done,
  sprite_dispatcher_if.master bus
);
  localparam int RRW = (NUM_R > 1) ? $clog2(NUM_R) : 1;

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t              state;
  logic [NUM_R-1:0]    claimed;
  logic [NUM_R-1:0]    sel;
  logic [NUM_R-1:0]    req;
  logic [NUM_R-1:0]    grant;
  logic [NUM_R-1:0]    valid_q;
  logic [RRW-1:0]      rr;
  logic [RRW-1:0]      gidx;
  logic [RRW-1:0]      j;
  logic [RRW-1:0]      rr_n;
  logic                found;
  logic                any_free;
  logic                go;
  logic                fb_q;
  logic                frame_active;
  logic [ADDR_W-1:0]   addr_mux;
  logic [NUM_R*8-1:0]  id_q;
  logic [NUM_R*8-1:0]  scale_q;
  logic [NUM_R*16-1:0] x_q;
  logic [NUM_R*16-1:0] y_q;

  // lowest free engine
  always_comb begin
    sel      = '0;
    any_free = 1'b0;
    for (int k = NUM_R - 1; k >= 0; k--) begin
      if (!claimed[k]) begin
        sel      = '0;
        sel[k]   = 1'b1;
        any_free = 1'b1;
      end
    end
  end

  assign go = !reset && !fb_resetting &&
              (state == IDLE) &&
              !bus.sprite_queue_is_empty &&
              any_free;

  // rr holds the index searched first
  always_comb begin
    req   = bus.r_mem_req & claimed &
            {NUM_R{!reset && !fb_resetting}};
    found = 1'b0;
    gidx  = '0;
    j     = '0;
    for (int i = 0; i < NUM_R; i++) begin
      j = RRW'((int'(rr) + i) % NUM_R);
      if (!found && req[j]) begin
        found = 1'b1;
        gidx  = j;
      end
    end
    grant = '0;
    if (found) grant[gidx] = 1'b1;
    rr_n     = RRW'((int'(gidx) + 1) % NUM_R);
    addr_mux = '0;
    for (int k = 0; k < NUM_R; k++) begin
      if (grant[k])
        addr_mux = bus.r_mem_addr[k*ADDR_W +: ADDR_W];
    end
  end

  assign frame_done = frame_active && !reset &&
                      !fb_resetting &&
                      bus.sprite_queue_is_empty &&
                      (claimed == '0) &&
                      (state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      claimed      <= '0;
      rr           <= '0;
      valid_q      <= '0;
      fb_q         <= 1'b0;
      frame_active <= 1'b0;
      id_q         <= '0;
      scale_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      fb_q <= fb_resetting;
      if (fb_q && !fb_resetting)
        frame_active <= 1'b1;
      else if (frame_done)
        frame_active <= 1'b0;
      if (found) rr <= rr_n;
      if (fb_resetting) begin
        state   <= IDLE;
        claimed <= '0;
        valid_q <= '0;
      end else begin
        valid_q <= grant;
        // done clears before a new claim can land
        claimed <= (claimed & ~bus.r_done) |
                   (go ? sel : '0);
        unique case (state)
          IDLE:   if (go) state <= SETTLE;
          SETTLE: state <= IDLE;
        endcase
        for (int k = 0; k < NUM_R; k++) begin
          if (go && sel[k]) begin
            id_q[k*8 +: 8]     <= bus.sprite_queue_sprite_id;
            scale_q[k*8 +: 8]  <= bus.sprite_queue_sprite_scale;
            x_q[k*16 +: 16]    <= bus.sprite_queue_sprite_x;
            y_q[k*16 +: 16]    <= bus.sprite_queue_sprite_y;
          end
        end
      end
    end
  end

  assign bus.sprite_queue_dequeue = go;
  assign bus.r_start       = go ? sel : '0;
  assign bus.r_id          = id_q;
  assign bus.r_x           = x_q;
  assign bus.r_y           = y_q;
  assign bus.r_scale       = scale_q;
  assign bus.r_mem_grant   = grant;
  assign bus.r_mem_valid   = valid_q;
  assign bus.sprite_r_en   = found;
  assign bus.sprite_r_addr = addr_mux;
endmodule

// File: tb/tb_sprite_dispatcher.sv
// Directed bench for sprite_dispatcher: dispatch, arbiter,
// frame boundary and reset cases with hand-computed values.
module tb_sprite_dispatcher;
  localparam int NUM_R  = 2;
  localparam int ADDR_W = 13;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic fb_resetting = 1'b0;
  logic frame_done;

  sprite_dispatcher_if #(.NUM_R(NUM_R), .ADDR_W(ADDR_W)) bus();

  sprite_dispatcher #(.NUM_R(NUM_R), .ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .fb_resetting (fb_resetting),
    .frame_done   (frame_done),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] ids [0:15];
  int qh = 0;
  int qt = 0;

  always @(posedge clock)
    if (bus.sprite_queue_dequeue) qh <= qh + 1;

  assign bus.sprite_queue_is_empty     = (qh == qt);
  assign bus.sprite_queue_sprite_id    = ids[qh];
  assign bus.sprite_queue_sprite_x     = {8'h00, ids[qh]} + 16'd100;
  assign bus.sprite_queue_sprite_y     = {8'h00, ids[qh]} + 16'd200;
  assign bus.sprite_queue_sprite_scale = ids[qh] + 8'd1;

  int checks = 0;
  int errors = 0;

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ids[i] = 8'h00;
    bus.r_done     = '0;
    bus.r_mem_req  = '0;
    bus.r_mem_addr = {13'h0122, 13'h0011};
    ids[0] = 8'd5;
    ids[1] = 8'd6;
    ids[2] = 8'd7;
    qt = 3;

    step; step; #1;
    expect_eq("rst_deq",   32'(bus.sprite_queue_dequeue), 0);
    expect_eq("rst_start", 32'(bus.r_start), 0);
    expect_eq("rst_id",    32'(bus.r_id), 0);
    expect_eq("rst_grant", 32'(bus.r_mem_grant), 0);
    expect_eq("rst_valid", 32'(bus.r_mem_valid), 0);
    expect_eq("rst_fdone", 32'(frame_done), 0);

    // dispatch three commands to two engines
    step; reset = 1'b0; #1;
    expect_eq("c0_deq",   32'(bus.sprite_queue_dequeue), 1);
    expect_eq("c0_start", 32'(bus.r_start), 32'h1);
    step; #1;
    expect_eq("c1_deq",   32'(bus.sprite_queue_dequeue), 0);
    expect_eq("c1_id",    32'(bus.r_id[7:0]), 5);
    expect_eq("c1_x",     32'(bus.r_x[15:0]), 105);
    expect_eq("c1_y",     32'(bus.r_y[15:0]), 205);
    expect_eq("c1_scale", 32'(bus.r_scale[7:0]), 6);
    step; #1;
    expect_eq("c2_deq",   32'(bus.sprite_queue_dequeue), 1);
    expect_eq("c2_start", 32'(bus.r_start), 32'h2);
    step; #1;
    expect_eq("c3_deq",   32'(bus.sprite_queue_dequeue), 0);
    step; #1;
    expect_eq("c4_busy",  32'(bus.sprite_queue_dequeue), 0);
    expect_eq("c4_ids",   32'(bus.r_id), 32'h0605);
    step; bus.r_done = 2'b01; #1;
    expect_eq("c5_done_deq", 32'(bus.sprite_queue_dequeue), 0);
    expect_eq("c5_done_st",  32'(bus.r_start), 0);
    step; bus.r_done = 2'b00; #1;
    expect_eq("c6_deq",   32'(bus.sprite_queue_dequeue), 1);
    expect_eq("c6_start", 32'(bus.r_start), 32'h1);
    step; #1;
    expect_eq("c7_id",    32'(bus.r_id[7:0]), 7);
    expect_eq("c7_deq",   32'(bus.sprite_queue_dequeue), 0);

    // round-robin arbiter with both engines claimed
    step; bus.r_mem_req = 2'b11; #1;
    expect_eq("a0_grant", 32'(bus.r_mem_grant), 32'h1);
    expect_eq("a0_en",    32'(bus.sprite_r_en), 1);
    expect_eq("a0_addr",  32'(bus.sprite_r_addr), 32'h011);
    step; #1;
    expect_eq("a1_grant", 32'(bus.r_mem_grant), 32'h2);
    expect_eq("a1_addr",  32'(bus.sprite_r_addr), 32'h122);
    expect_eq("a1_valid", 32'(bus.r_mem_valid), 32'h1);
    step; #1;
    expect_eq("a2_grant", 32'(bus.r_mem_grant), 32'h1);
    expect_eq("a2_valid", 32'(bus.r_mem_valid), 32'h2);
    step; #1;
    expect_eq("a3_grant", 32'(bus.r_mem_grant), 32'h2);
    expect_eq("a3_valid", 32'(bus.r_mem_valid), 32'h1);
    step; bus.r_mem_req = 2'b00; #1;
    expect_eq("a4_grant", 32'(bus.r_mem_grant), 0);
    expect_eq("a4_en",    32'(bus.sprite_r_en), 0);
    expect_eq("a4_valid", 32'(bus.r_mem_valid), 32'h2);
    step; #1;
    expect_eq("a5_valid", 32'(bus.r_mem_valid), 0);

    // framebuffer reset with queue pending
    step;
    fb_resetting = 1'b1;
    bus.r_mem_req = 2'b11;
    ids[3] = 8'd8;
    ids[4] = 8'd9;
    qt = 5;
    #1;
    expect_eq("f0_deq",   32'(bus.sprite_queue_dequeue), 0);
    expect_eq("f0_grant", 32'(bus.r_mem_grant), 0);
    step; #1;
    expect_eq("f1_deq",   32'(bus.sprite_queue_dequeue), 0);
    expect_eq("f1_grant", 32'(bus.r_mem_grant), 0);
    expect_eq("f1_valid", 32'(bus.r_mem_valid), 0);
    expect_eq("f1_fdone", 32'(frame_done), 0);
    step; fb_resetting = 1'b0; bus.r_mem_req = 2'b00; #1;
    expect_eq("f2_deq",   32'(bus.sprite_queue_dequeue), 1);
    expect_eq("f2_start", 32'(bus.r_start), 32'h1);
    step; #1;
    expect_eq("f3_id",    32'(bus.r_id[7:0]), 8);
    expect_eq("f3_fdone", 32'(frame_done), 0);
    step; #1;
    expect_eq("f4_deq",   32'(bus.sprite_queue_dequeue), 1);
    expect_eq("f4_start", 32'(bus.r_start), 32'h2);
    step; #1;
    expect_eq("f5_ids",   32'(bus.r_id), 32'h0908);
    step; bus.r_done = 2'b11; #1;
    expect_eq("f6_fdone", 32'(frame_done), 0);
    step; bus.r_done = 2'b00; bus.r_mem_req = 2'b10; #1;
    expect_eq("f7_fdone", 32'(frame_done), 1);
    expect_eq("f7_unclaimed_grant", 32'(bus.r_mem_grant), 0);
    step; bus.r_mem_req = 2'b00; #1;
    expect_eq("f8_fdone", 32'(frame_done), 0);

    // empty frame: one pulse after fb_resetting falls
    step; fb_resetting = 1'b1; #1;
    expect_eq("e0_fdone", 32'(frame_done), 0);
    step; #1;
    expect_eq("e1_fdone", 32'(frame_done), 0);
    step; fb_resetting = 1'b0; #1;
    expect_eq("e2_fdone", 32'(frame_done), 0);
    step; #1;
    expect_eq("e3_fdone", 32'(frame_done), 1);
    step; #1;
    expect_eq("e4_fdone", 32'(frame_done), 0);

    // reset pulsed during SETTLE
    step; ids[5] = 8'd10; ids[6] = 8'd11; qt = 7; #1;
    expect_eq("r0_deq",   32'(bus.sprite_queue_dequeue), 1);
    expect_eq("r0_start", 32'(bus.r_start), 32'h1);
    step; reset = 1'b1; bus.r_mem_req = 2'b01; #1;
    expect_eq("r1_deq",   32'(bus.sprite_queue_dequeue), 0);
    expect_eq("r1_grant", 32'(bus.r_mem_grant), 0);
    step; #1;
    expect_eq("r2_deq",   32'(bus.sprite_queue_dequeue), 0);
    expect_eq("r2_start", 32'(bus.r_start), 0);
    expect_eq("r2_id",    32'(bus.r_id), 0);
    expect_eq("r2_valid", 32'(bus.r_mem_valid), 0);
    expect_eq("r2_grant", 32'(bus.r_mem_grant), 0);
    step; reset = 1'b0; bus.r_mem_req = 2'b00; #1;
    expect_eq("r3_deq",   32'(bus.sprite_queue_dequeue), 1);
    expect_eq("r3_start", 32'(bus.r_start), 32'h1);
    step; #1;
    expect_eq("r4_id",    32'(bus.r_id), 32'h000B);
    expect_eq("r4_deq",   32'(bus.sprite_queue_dequeue), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
